// File: rtl/cpu16_pkg.sv
// -----------------------------------------------------------------------------
// cpu16_pkg
// Shared constants and types for the 16-bit CPU datapath.
//   DATA_W      : datapath width, must match the ALU width
//   REG_ADDR_W  : register-file address width (register 0 reads as zero)
//   OP_*        : 3-bit ALU opcode encoding
//   ctrl_t      : decoded control bundle carried through ID/EX
//   reg_match() : "source register is produced by this writer" test
// -----------------------------------------------------------------------------
package cpu16_pkg;

   localparam int DATA_W     = 16;
   localparam int REG_ADDR_W = 3;

   // ALU opcodes; BNegate turns OP_ADD into a subtract and feeds OP_SLT.
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_AND = 3'd1;
   localparam logic [2:0] OP_OR  = 3'd2;
   localparam logic [2:0] OP_XOR = 3'd3;
   localparam logic [2:0] OP_SLT = 3'd4;
   localparam logic [2:0] OP_SLL = 3'd5;
   localparam logic [2:0] OP_SRL = 3'd6;
   localparam logic [2:0] OP_SRA = 3'd7;

   typedef struct packed {
      logic [3:0]            shamt;
      logic                  b_negate;
      logic [2:0]            op;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
      logic                  use_imm;
   } ctrl_t;

   // Register 0 is hardwired zero, so it never matches a producer.
   function automatic logic reg_match(input logic [REG_ADDR_W-1:0] src,
                                      input logic [REG_ADDR_W-1:0] rd,
                                      input logic                  we);
      return we && (src != '0) && (src == rd);
   endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// -----------------------------------------------------------------------------
// fwd_mux
// Operand forwarding selector for one source register of the ID/EX stage.
// Ports:
//   src                : held source register number
//   held               : held register-file value for that source
//   ex_mem_reg_write/rd/result : youngest in-flight producer
//   mem_wb_reg_write/rd/result : older in-flight producer
//   value              : selected operand (EX/MEM beats MEM/WB beats held)
// -----------------------------------------------------------------------------
module fwd_mux
   import cpu16_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] src,
   input  logic [DATA_W-1:0]     held,
   input  logic                  ex_mem_reg_write,
   input  logic [REG_ADDR_W-1:0] ex_mem_rd,
   input  logic [DATA_W-1:0]     ex_mem_result,
   input  logic                  mem_wb_reg_write,
   input  logic [REG_ADDR_W-1:0] mem_wb_rd,
   input  logic [DATA_W-1:0]     mem_wb_result,
   output logic [DATA_W-1:0]     value
);

   always_comb begin
      value = held;
      // The EX/MEM check comes last so the youngest producer wins.
      if (reg_match(src, mem_wb_rd, mem_wb_reg_write)) value = mem_wb_result;
      if (reg_match(src, ex_mem_rd, ex_mem_reg_write)) value = ex_mem_result;
   end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// Decode-to-execute pipeline register feeding the 16-bit ALU. Holds one
// decoded instruction, forwards RAW results from EX/MEM and MEM/WB, and
// inserts a one-cycle bubble on load-use hazards. Widths come from cpu16_pkg
// (DATA_W, REG_ADDR_W).
//
// Configuration macro: ID_EX_FWD_EN
//   defined   : fwd_mux per operand; only load-use stalls decode.
//   undefined : operands come straight from the held values; decode also
//               stalls while any in-flight writer (held, EX/MEM, MEM/WB)
//               targets a nonzero incoming source register.
//
// Ports:
//   Clock, ResetN          : rising-edge clock, asynchronous active-low reset
//   Flush                  : drop held and incoming instruction
//   InValid / InReady      : decode-side handshake
//   InRsAddr..InMemWrite   : decoded instruction fields
//   ExMem*, MemWb*         : forwarding sources (write enable, rd, data)
//   OutValid / OutReady    : execute-side handshake
//   A, B, Shamt, BNegate, Op : ALU inputs
//   StoreData              : forwarded Rt for stores
//   OutRd, OutRegWrite, OutMemRead, OutMemWrite : control passed downstream
// -----------------------------------------------------------------------------
module id_ex_stage
   import cpu16_pkg::*;
(
   input  logic                  Clock,
   input  logic                  ResetN,
   input  logic                  Flush,
   input  logic                  InValid,
   output logic                  InReady,
   input  logic [REG_ADDR_W-1:0] InRsAddr,
   input  logic [REG_ADDR_W-1:0] InRtAddr,
   input  logic [DATA_W-1:0]     InRsVal,
   input  logic [DATA_W-1:0]     InRtVal,
   input  logic [DATA_W-1:0]     InImm,
   input  logic                  InUseImm,
   input  logic [3:0]            InShamt,
   input  logic                  InBNegate,
   input  logic [2:0]            InOp,
   input  logic [REG_ADDR_W-1:0] InRd,
   input  logic                  InRegWrite,
   input  logic                  InMemRead,
   input  logic                  InMemWrite,
   input  logic                  ExMemRegWrite,
   input  logic [REG_ADDR_W-1:0] ExMemRd,
   input  logic [DATA_W-1:0]     ExMemResult,
   input  logic                  MemWbRegWrite,
   input  logic [REG_ADDR_W-1:0] MemWbRd,
   input  logic [DATA_W-1:0]     MemWbResult,
   output logic                  OutValid,
   input  logic                  OutReady,
   output logic [DATA_W-1:0]     A,
   output logic [DATA_W-1:0]     B,
   output logic [3:0]            Shamt,
   output logic                  BNegate,
   output logic [2:0]            Op,
   output logic [DATA_W-1:0]     StoreData,
   output logic [REG_ADDR_W-1:0] OutRd,
   output logic                  OutRegWrite,
   output logic                  OutMemRead,
   output logic                  OutMemWrite
);

   logic                  valid_reg;
   logic [REG_ADDR_W-1:0] rs_addr_reg;
   logic [REG_ADDR_W-1:0] rt_addr_reg;
   logic [DATA_W-1:0]     rs_val_reg;
   logic [DATA_W-1:0]     rt_val_reg;
   logic [DATA_W-1:0]     imm_reg;
   ctrl_t                 ctrl_reg;

   ctrl_t                 in_ctrl;
   logic                  load_use;
   logic                  src_busy;
   logic                  capture;

   // Operand 0 is Rs, operand 1 is Rt.
   logic [DATA_W-1:0]     src_held [2];
   logic [DATA_W-1:0]     src_fwd  [2];

   assign in_ctrl = '{shamt:     InShamt,
                      b_negate:  InBNegate,
                      op:        InOp,
                      rd:        InRd,
                      reg_write: InRegWrite,
                      mem_read:  InMemRead,
                      mem_write: InMemWrite,
                      use_imm:   InUseImm};

   // A held load cannot forward until MEM/WB, so a dependent consumer must
   // wait one cycle; the drain that follows forms the bubble.
   assign load_use = valid_reg & ctrl_reg.mem_read & (ctrl_reg.rd != '0) & InValid &
                     ((InRsAddr == ctrl_reg.rd) | (InRtAddr == ctrl_reg.rd));

   assign src_held[0] = rs_val_reg;
   assign src_held[1] = rt_val_reg;

`ifdef ID_EX_FWD_EN
   logic [REG_ADDR_W-1:0] src_addr [2];

   assign src_addr[0] = rs_addr_reg;
   assign src_addr[1] = rt_addr_reg;
   assign src_busy    = 1'b0;

   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_mux u_fwd_mux (
         .src              (src_addr[gi]),
         .held             (src_held[gi]),
         .ex_mem_reg_write (ExMemRegWrite),
         .ex_mem_rd        (ExMemRd),
         .ex_mem_result    (ExMemResult),
         .mem_wb_reg_write (MemWbRegWrite),
         .mem_wb_rd        (MemWbRd),
         .mem_wb_result    (MemWbResult),
         .value            (src_fwd[gi])
      );
   end
`else
   logic unused_fwd_data;

   // Without forwarding, decode waits until every producer of a source has
   // retired past MEM/WB and the register file holds the result.
   function automatic logic producer_pending(input logic [REG_ADDR_W-1:0] src);
      return reg_match(src, ctrl_reg.rd, valid_reg & ctrl_reg.reg_write) |
             reg_match(src, ExMemRd, ExMemRegWrite) |
             reg_match(src, MemWbRd, MemWbRegWrite);
   endfunction

   assign src_busy = InValid & (producer_pending(InRsAddr) | producer_pending(InRtAddr));

   for (genvar gi = 0; gi < 2; gi++) begin : g_nofwd
      assign src_fwd[gi] = src_held[gi];
   end

   // Data forwarding inputs and held source numbers have no reader here.
   assign unused_fwd_data = ^{ExMemResult, MemWbResult, rs_addr_reg, rt_addr_reg};
`endif

   assign InReady = (~valid_reg | OutReady) & ~load_use & ~src_busy & ~Flush;
   assign capture = InValid & InReady;

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         valid_reg   <= 1'b0;
         rs_addr_reg <= '0;
         rt_addr_reg <= '0;
         rs_val_reg  <= '0;
         rt_val_reg  <= '0;
         imm_reg     <= '0;
         ctrl_reg    <= '0;
      end else if (Flush) begin
         valid_reg <= 1'b0;
      end else if (capture) begin
         valid_reg   <= 1'b1;
         rs_addr_reg <= InRsAddr;
         rt_addr_reg <= InRtAddr;
         rs_val_reg  <= InRsVal;
         rt_val_reg  <= InRtVal;
         imm_reg     <= InImm;
         ctrl_reg    <= in_ctrl;
      end else if (valid_reg & OutReady) begin
         valid_reg <= 1'b0;
      end
      // Otherwise stalled (or idle): everything holds.
   end

   assign OutValid    = valid_reg;
   assign A           = src_fwd[0];
   assign B           = ctrl_reg.use_imm ? imm_reg : src_fwd[1];
   assign StoreData   = src_fwd[1];
   assign Shamt       = ctrl_reg.shamt;
   assign BNegate     = ctrl_reg.b_negate;
   assign Op          = ctrl_reg.op;
   assign OutRd       = ctrl_reg.rd;
   assign OutRegWrite = ctrl_reg.reg_write;
   assign OutMemRead  = ctrl_reg.mem_read;
   assign OutMemWrite = ctrl_reg.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the held instruction.
// Follows ID_EX_FWD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
   import cpu16_pkg::*;

   logic        Clock = 1'b0;
   logic        ResetN;
   logic        Flush;
   logic        InValid;
   logic        InReady;
   logic [2:0]  InRsAddr, InRtAddr;
   logic [15:0] InRsVal, InRtVal, InImm;
   logic        InUseImm;
   logic [3:0]  InShamt;
   logic        InBNegate;
   logic [2:0]  InOp;
   logic [2:0]  InRd;
   logic        InRegWrite, InMemRead, InMemWrite;
   logic        ExMemRegWrite;
   logic [2:0]  ExMemRd;
   logic [15:0] ExMemResult;
   logic        MemWbRegWrite;
   logic [2:0]  MemWbRd;
   logic [15:0] MemWbResult;
   logic        OutValid;
   logic        OutReady;
   logic [15:0] A, B, StoreData;
   logic [3:0]  Shamt;
   logic        BNegate;
   logic [2:0]  Op;
   logic [2:0]  OutRd;
   logic        OutRegWrite, OutMemRead, OutMemWrite;

   int checks = 0;
   int errors = 0;

   always #5 Clock = ~Clock;

   id_ex_stage dut (
      .Clock(Clock), .ResetN(ResetN), .Flush(Flush),
      .InValid(InValid), .InReady(InReady),
      .InRsAddr(InRsAddr), .InRtAddr(InRtAddr),
      .InRsVal(InRsVal), .InRtVal(InRtVal), .InImm(InImm),
      .InUseImm(InUseImm), .InShamt(InShamt), .InBNegate(InBNegate),
      .InOp(InOp), .InRd(InRd),
      .InRegWrite(InRegWrite), .InMemRead(InMemRead), .InMemWrite(InMemWrite),
      .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd), .ExMemResult(ExMemResult),
      .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbResult(MemWbResult),
      .OutValid(OutValid), .OutReady(OutReady),
      .A(A), .B(B), .Shamt(Shamt), .BNegate(BNegate), .Op(Op),
      .StoreData(StoreData), .OutRd(OutRd),
      .OutRegWrite(OutRegWrite), .OutMemRead(OutMemRead), .OutMemWrite(OutMemWrite)
   );

   // Model of the instruction the stage should be holding.
   logic        m_valid;
   logic [2:0]  m_rs, m_rt, m_rd, m_op;
   logic [15:0] m_rsv, m_rtv, m_imm;
   logic [3:0]  m_shamt;
   logic        m_bneg, m_rw, m_mr, m_mw, m_ui;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_op = 0;
      m_rsv = 0; m_rtv = 0; m_imm = 0; m_shamt = 0;
      m_bneg = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_ui = 0;
   endtask

   // Value the ALU should see for a held source register.
   function automatic logic [15:0] operand(input logic [2:0] src, input logic [15:0] held);
`ifdef ID_EX_FWD_EN
      if (src != 0 && ExMemRegWrite && ExMemRd == src) return ExMemResult;
      if (src != 0 && MemWbRegWrite && MemWbRd == src) return MemWbResult;
`endif
      return held;
   endfunction

   function automatic bit writer_in_flight(input logic [2:0] src);
      if (src == 0) return 1'b0;
      return (m_valid && m_rw && m_rd == src) ||
             (ExMemRegWrite && ExMemRd == src) ||
             (MemWbRegWrite && MemWbRd == src);
   endfunction

   function automatic bit exp_ready();
      bit lu;
      lu = m_valid && m_mr && m_rd != 0 && InValid &&
           (InRsAddr == m_rd || InRtAddr == m_rd);
`ifndef ID_EX_FWD_EN
      if (InValid && (writer_in_flight(InRsAddr) || writer_in_flight(InRtAddr))) return 1'b0;
`endif
      return (!m_valid || OutReady) && !lu && !Flush;
   endfunction

   task automatic compare_all(input string where);
      logic [15:0] ea, eb;
      ea = operand(m_rs, m_rsv);
      eb = m_ui ? m_imm : operand(m_rt, m_rtv);
      chk({where, ".InReady"},   InReady,   exp_ready());
      chk({where, ".OutValid"},  OutValid,  m_valid);
      chk({where, ".A"},         A,         ea);
      chk({where, ".B"},         B,         eb);
      chk({where, ".StoreData"}, StoreData, operand(m_rt, m_rtv));
      chk({where, ".ctrl"},
          {Shamt, BNegate, Op, OutRd, OutRegWrite, OutMemRead, OutMemWrite},
          {m_shamt, m_bneg, m_op, m_rd, m_rw, m_mr, m_mw});
   endtask

   // One clock: check at the falling edge, then advance the model over the
   // rising edge. Inputs are only changed from posedge+1 onwards.
   task automatic tick(input string where);
      bit fl, cap, drn;
      @(negedge Clock);
      compare_all(where);
      fl  = Flush;
      cap = InValid && exp_ready();
      drn = m_valid && OutReady;
      @(posedge Clock);
      #1;
      if (fl) begin
         m_valid = 0;
      end else if (cap) begin
         m_valid = 1; m_rs = InRsAddr; m_rt = InRtAddr; m_rsv = InRsVal; m_rtv = InRtVal;
         m_imm = InImm; m_ui = InUseImm; m_shamt = InShamt; m_bneg = InBNegate;
         m_op = InOp; m_rd = InRd; m_rw = InRegWrite; m_mr = InMemRead; m_mw = InMemWrite;
         $display("txn %s: captured rd=%0d op=%0d rs=%0d rt=%0d", where, m_rd, m_op, m_rs, m_rt);
      end else if (drn) begin
         m_valid = 0;
      end
   endtask

   task automatic idle_inputs();
      Flush = 0; InValid = 0; InRsAddr = 0; InRtAddr = 0; InRsVal = 0; InRtVal = 0;
      InImm = 0; InUseImm = 0; InShamt = 0; InBNegate = 0; InOp = OP_ADD; InRd = 0;
      InRegWrite = 0; InMemRead = 0; InMemWrite = 0;
      ExMemRegWrite = 0; ExMemRd = 0; ExMemResult = 0;
      MemWbRegWrite = 0; MemWbRd = 0; MemWbResult = 0; OutReady = 0;
   endtask

   initial begin
      idle_inputs();
      ResetN = 0;
      model_reset();
      repeat (2) @(posedge Clock);
      #1;
      chk("reset.OutValid", OutValid, 1'b0);
      chk("reset.A", A, 16'h0000);
      compare_all("reset");
      ResetN = 1;

      // Plain accept, immediate B operand.
      InValid = 1; InRsAddr = 1; InRsVal = 16'h0005; InImm = 16'h0003; InUseImm = 1;
      InOp = OP_ADD; InRd = 4; InRegWrite = 1; OutReady = 1;
      tick("accept");
      InValid = 0; OutReady = 0; #1;
      chk("accept.OutValid", OutValid, 1'b1);
      chk("accept.A", A, 16'h0005);
      chk("accept.B", B, 16'h0003);

      // Forwarding priority on held Rs=2.
      OutReady = 1; InValid = 1; InRsAddr = 2; InRsVal = 16'h7777; InUseImm = 0;
      InRtAddr = 0; InRtVal = 16'h0011; InRd = 6;
      tick("fwd_load");
      InValid = 0; OutReady = 0;
      ExMemRegWrite = 1; ExMemRd = 2; ExMemResult = 16'h1234;
      MemWbRegWrite = 1; MemWbRd = 2; MemWbResult = 16'hBEEF;
      #1;
`ifdef ID_EX_FWD_EN
      chk("fwd.exmem_priority", A, 16'h1234);
`else
      chk("fwd.held_only", A, 16'h7777);
`endif
      tick("fwd_hold");
      ExMemRegWrite = 0; #1;
`ifdef ID_EX_FWD_EN
      chk("fwd.memwb", A, 16'hBEEF);
`else
      chk("fwd.memwb_held_only", A, 16'h7777);
`endif
      // Register 0 never forwards.
      ExMemRegWrite = 1; ExMemRd = 0; MemWbRegWrite = 1; MemWbRd = 0;
      OutReady = 1; InValid = 1; InRsAddr = 0; InRsVal = 16'h4444;
      tick("rs0_load");
      InValid = 0; OutReady = 0; #1;
      chk("fwd.rs0", A, 16'h4444);
      ExMemRegWrite = 0; MemWbRegWrite = 0;

      // Load-use: held load to r3, consumer reads Rt=3.
      OutReady = 1; InValid = 1; InRsAddr = 1; InRtAddr = 0; InRd = 3;
      InMemRead = 1; InRegWrite = 1; InUseImm = 1; InImm = 16'h0000;
      tick("load");
      InRsAddr = 0; InRtAddr = 3; InRtVal = 16'h0042; InUseImm = 0; InMemRead = 0;
      InRd = 5; InOp = OP_AND;
      #1;
      chk("loaduse.c0_InReady", InReady, 1'b0);
      tick("loaduse_c0");
      chk("loaduse.bubble_OutValid", OutValid, 1'b0);
      chk("loaduse.c1_InReady", InReady, 1'b1);
      tick("loaduse_c1");
      InValid = 0; OutReady = 0;
      MemWbRegWrite = 1; MemWbRd = 3; MemWbResult = 16'hCAFE; #1;
      chk("loaduse.c2_OutValid", OutValid, 1'b1);
`ifdef ID_EX_FWD_EN
      chk("loaduse.c2_B", B, 16'hCAFE);
`else
      chk("loaduse.c2_B", B, 16'h0042);
`endif
      MemWbRegWrite = 0;

      // Downstream stall for three cycles with decode waiting.
      InValid = 1; InRsAddr = 1; InRtAddr = 2; InRd = 6; InOp = OP_XOR;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall.InReady", InReady, 1'b0);
         chk("stall.Op", Op, OP_AND);
         tick("stall");
      end

      // Flush with both held and incoming valid.
      OutReady = 1; Flush = 1;
      tick("flush");
      Flush = 0; InValid = 0; #1;
      chk("flush.OutValid", OutValid, 1'b0);
      chk("flush.OutRd_not_captured", OutRd, 3'd5);

      // Asynchronous reset between edges.
      InValid = 1; InRd = 7; InRsAddr = 4; InRsVal = 16'h00AA;
      tick("pre_reset");
      InValid = 0; OutReady = 0; #1;
      chk("areset.before", OutValid, 1'b1);
      #2 ResetN = 0;
      #1;
      chk("areset.OutValid", OutValid, 1'b0);
      chk("areset.OutRd", OutRd, 3'd0);
      model_reset();
      @(posedge Clock);
      #1 ResetN = 1;
      InValid = 1; OutReady = 1; InRd = 2; InRsAddr = 1; InRsVal = 16'h0101;
      tick("post_reset");
      chk("areset.accept_OutValid", OutValid, 1'b1);
      chk("areset.accept_A", A, 16'h0101);

      // Random traffic.
      for (int n = 0; n < 300; n++) begin
         InValid       = ($urandom_range(0, 3) != 0);
         Flush         = ($urandom_range(0, 15) == 0);
         OutReady      = ($urandom_range(0, 3) != 0);
         InRsAddr      = 3'($urandom_range(0, 7));
         InRtAddr      = 3'($urandom_range(0, 7));
         InRsVal       = 16'($urandom);
         InRtVal       = 16'($urandom);
         InImm         = 16'($urandom);
         InUseImm      = 1'($urandom);
         InShamt       = 4'($urandom);
         InBNegate     = 1'($urandom);
         InOp          = 3'($urandom);
         InRd          = 3'($urandom_range(0, 7));
         InRegWrite    = 1'($urandom);
         InMemRead     = ($urandom_range(0, 2) == 0);
         InMemWrite    = 1'($urandom);
         ExMemRegWrite = ($urandom_range(0, 2) == 0);
         ExMemRd       = 3'($urandom_range(0, 7));
         ExMemResult   = 16'($urandom);
         MemWbRegWrite = ($urandom_range(0, 2) == 0);
         MemWbRd       = 3'($urandom_range(0, 7));
         MemWbResult   = 16'($urandom);
         tick("rand");
      end

      idle_inputs();
      tick("final");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
